// File: rtl/ise_color_accum.sv
// Per-image dominant-colour accumulator: classifies each pixel by its strongest channel
// and emits one {index, colour, count, sum} record per image over valid/ready.
module ise_color_accum #(
    parameter int PIX_PER_IMG = 16384,
    parameter int CNT_W       = 15,
    parameter int SUM_W       = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [4:0]       image_in_index,
    input  logic [23:0]      pixel_in,
    output logic             busy,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [4:0]       rec_index,
    output logic [1:0]       rec_color,
    output logic [CNT_W-1:0] rec_count,
    output logic [SUM_W-1:0] rec_sum,
    output logic             idx_err
);
    localparam int PIX_W = $clog2(PIX_PER_IMG);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_PER_IMG - 1);

    typedef enum logic [1:0] {ACCUM, FIN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [SUM_W-1:0] sum_q [3];
    logic [SUM_W-1:0] sum_d [3];
    logic [4:0]       idx_q, idx_d;
    logic             idx_err_q, idx_err_d;
    logic             busy_q, busy_d;
    logic [4:0]       pend_idx_q, pend_idx_d;
    logic [1:0]       pend_color_q, pend_color_d;
    logic [CNT_W-1:0] pend_count_q, pend_count_d;
    logic [SUM_W-1:0] pend_sum_q, pend_sum_d;
    logic             rec_valid_q, rec_valid_d;
    logic [4:0]       rec_index_q, rec_index_d;
    logic [1:0]       rec_color_q, rec_color_d;
    logic [CNT_W-1:0] rec_count_q, rec_count_d;
    logic [SUM_W-1:0] rec_sum_q, rec_sum_d;

    logic [7:0]       pix_r, pix_g, pix_b, pix_val;
    logic [1:0]       pix_cls, win_cls;
    logic [CNT_W-1:0] win_count;
    logic [SUM_W-1:0] win_sum;
    logic             accept, slot_free;

    assign pix_r = pixel_in[23:16];
    assign pix_g = pixel_in[15:8];
    assign pix_b = pixel_in[7:0];

    // Pixel class and image winner both break ties R > G > B.
    always_comb begin
        pix_cls = 2'd0;
        pix_val = pix_r;
        if (pix_r >= pix_g && pix_r >= pix_b) begin
            pix_cls = 2'd0;
            pix_val = pix_r;
        end else if (pix_g >= pix_b) begin
            pix_cls = 2'd1;
            pix_val = pix_g;
        end else begin
            pix_cls = 2'd2;
            pix_val = pix_b;
        end
    end

    always_comb begin
        win_cls   = 2'd0;
        win_count = cnt_q[0];
        win_sum   = sum_q[0];
        if (cnt_q[0] >= cnt_q[1] && cnt_q[0] >= cnt_q[2]) begin
            win_cls   = 2'd0;
            win_count = cnt_q[0];
            win_sum   = sum_q[0];
        end else if (cnt_q[1] >= cnt_q[2]) begin
            win_cls   = 2'd1;
            win_count = cnt_q[1];
            win_sum   = sum_q[1];
        end else begin
            win_cls   = 2'd2;
            win_count = cnt_q[2];
            win_sum   = sum_q[2];
        end
    end

    assign accept    = in_valid && !busy_q;
    assign slot_free = !rec_valid_q || rec_ready;

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        idx_d        = idx_q;
        idx_err_d    = idx_err_q;
        pend_idx_d   = pend_idx_q;
        pend_color_d = pend_color_q;
        pend_count_d = pend_count_q;
        pend_sum_d   = pend_sum_q;
        rec_valid_d  = rec_valid_q && !rec_ready;
        rec_index_d  = rec_index_q;
        rec_color_d  = rec_color_q;
        rec_count_d  = rec_count_q;
        rec_sum_d    = rec_sum_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    for (int k = 0; k < 3; k++) begin
                        if (pix_cls == 2'(k)) begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                            sum_d[k] = sum_q[k] + SUM_W'(pix_val);
                        end
                    end
                    if (pix_cnt_q == '0) begin
                        idx_d = image_in_index;
                    end else if (image_in_index != idx_q) begin
                        idx_err_d = 1'b1;
                    end
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                pend_idx_d   = idx_q;
                pend_color_d = win_cls;
                pend_count_d = win_count;
                pend_sum_d   = win_sum;
                pix_cnt_d    = '0;
                for (int k = 0; k < 3; k++) begin
                    cnt_d[k] = '0;
                    sum_d[k] = '0;
                end
                if (slot_free) begin
                    rec_valid_d = 1'b1;
                    rec_index_d = idx_q;
                    rec_color_d = win_cls;
                    rec_count_d = win_count;
                    rec_sum_d   = win_sum;
                    state_d     = ACCUM;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Slot is occupied here, so rec_ready alone means it drains this edge.
                if (rec_ready) begin
                    rec_valid_d = 1'b1;
                    rec_index_d = pend_idx_q;
                    rec_color_d = pend_color_q;
                    rec_count_d = pend_count_q;
                    rec_sum_d   = pend_sum_q;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        busy_d = (state_d != ACCUM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ACCUM;
            pix_cnt_q    <= '0;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= '0;
                sum_q[k] <= '0;
            end
            idx_q        <= '0;
            idx_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            pend_idx_q   <= '0;
            pend_color_q <= '0;
            pend_count_q <= '0;
            pend_sum_q   <= '0;
            rec_valid_q  <= 1'b0;
            rec_index_q  <= '0;
            rec_color_q  <= '0;
            rec_count_q  <= '0;
            rec_sum_q    <= '0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            idx_q        <= idx_d;
            idx_err_q    <= idx_err_d;
            busy_q       <= busy_d;
            pend_idx_q   <= pend_idx_d;
            pend_color_q <= pend_color_d;
            pend_count_q <= pend_count_d;
            pend_sum_q   <= pend_sum_d;
            rec_valid_q  <= rec_valid_d;
            rec_index_q  <= rec_index_d;
            rec_color_q  <= rec_color_d;
            rec_count_q  <= rec_count_d;
            rec_sum_q    <= rec_sum_d;
        end
    end

    assign busy      = busy_q;
    assign rec_valid = rec_valid_q;
    assign rec_index = rec_index_q;
    assign rec_color = rec_color_q;
    assign rec_count = rec_count_q;
    assign rec_sum   = rec_sum_q;
    assign idx_err   = idx_err_q;

endmodule
